// File: rtl/alarm_snooze_ctrl_pkg.sv
// Shared types for the alarm ring/snooze controller.
package alarm_snooze_ctrl_pkg;

   // FSM encoding; the numeric values are visible on the STATE output.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_t;

   // BCD digit widths produced by the 24-hour time counters.
   localparam int DIGIT_W    = 4;  // any ones digit
   localparam int HR_TENS_W  = 2;  // hour tens 0..2
   localparam int MIN_TENS_W = 3;  // minute tens 0..5
   localparam int SEC_TENS_W = 3;  // second tens 0..5

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/alarm_snooze_ctrl_if.sv
// Tick, key, time/alarm digit and indicator signals of the alarm controller.
interface alarm_snooze_ctrl_if;
   import alarm_snooze_ctrl_pkg::*;

   logic                  ENABLE;
   logic                  ENABLE_BUZZ;
   logic                  ARM;
   logic                  SNOOZE;
   logic                  STOP;
   logic [DIGIT_W-1:0]    CNT10T;
   logic [HR_TENS_W-1:0]  CNT3T;
   logic [DIGIT_W-1:0]    CNT10M;
   logic [MIN_TENS_W-1:0] CNT6M;
   logic [DIGIT_W-1:0]    CNT10;
   logic [SEC_TENS_W-1:0] CNT6;
   logic [DIGIT_W-1:0]    AL_CNT10T;
   logic [HR_TENS_W-1:0]  AL_CNT3T;
   logic [DIGIT_W-1:0]    AL_CNT10M;
   logic [MIN_TENS_W-1:0] AL_CNT6M;
   logic                  BUZZ;
   logic                  LED;
   logic [1:0]            STATE;
   logic [1:0]            SNZ_LEFT;

   modport master (
      output ENABLE, ENABLE_BUZZ, ARM, SNOOZE, STOP,
      output CNT10T, CNT3T, CNT10M, CNT6M, CNT10, CNT6,
      output AL_CNT10T, AL_CNT3T, AL_CNT10M, AL_CNT6M,
      input  BUZZ, LED, STATE, SNZ_LEFT
   );

   modport slave (
      input  ENABLE, ENABLE_BUZZ, ARM, SNOOZE, STOP,
      input  CNT10T, CNT3T, CNT10M, CNT6M, CNT10, CNT6,
      input  AL_CNT10T, AL_CNT3T, AL_CNT10M, AL_CNT6M,
      output BUZZ, LED, STATE, SNZ_LEFT
   );

endinterface

// File: rtl/alarm_snooze_ctrl_match.sv
// Time/alarm compare with a rising-edge detector: one trigger per alarm minute.
module alarm_match
   import alarm_snooze_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  arm,
   input  logic [DIGIT_W-1:0]    hr_ones,
   input  logic [HR_TENS_W-1:0]  hr_tens,
   input  logic [DIGIT_W-1:0]    min_ones,
   input  logic [MIN_TENS_W-1:0] min_tens,
   input  logic [DIGIT_W-1:0]    sec_ones,
   input  logic [SEC_TENS_W-1:0] sec_tens,
   input  logic [DIGIT_W-1:0]    al_hr_ones,
   input  logic [HR_TENS_W-1:0]  al_hr_tens,
   input  logic [DIGIT_W-1:0]    al_min_ones,
   input  logic [MIN_TENS_W-1:0] al_min_tens,
   output logic                  trigger
);

   logic match;
   logic match_q;

   assign match = (hr_ones  == al_hr_ones)  && (hr_tens  == al_hr_tens) &&
                  (min_ones == al_min_ones) && (min_tens == al_min_tens) &&
                  (sec_ones == '0) && (sec_tens == '0);

   // Previous match; resets high so releasing reset inside the alarm second
   // does not look like a fresh edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) match_q <= 1'b1;
      else        match_q <= match;
   end

   assign trigger = match & ~match_q & arm;

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm ring/snooze FSM driving the buzzer and alarm LED.
module alarm_snooze_ctrl
   import alarm_snooze_ctrl_pkg::*;
#(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
)(
   input  logic                CLK,
   input  logic                RESET,
   alarm_snooze_ctrl_if.slave  bus
);

   localparam int         TW      = $clog2(max_int(RING_SEC, SNOOZE_SEC) + 1);
   localparam logic [1:0] SNZ_MAX = 2'(MAX_SNOOZE);

   state_t        state;
   logic [TW-1:0] timer;
   logic [1:0]    snz_left;
   logic          phase;
   logic          cadence;
   logic          buzz;
   logic          led;
   logic          trigger;

   alarm_match u_match (
      .clk         (CLK),
      .rst_n       (RESET),
      .arm         (bus.ARM),
      .hr_ones     (bus.CNT10T),
      .hr_tens     (bus.CNT3T),
      .min_ones    (bus.CNT10M),
      .min_tens    (bus.CNT6M),
      .sec_ones    (bus.CNT10),
      .sec_tens    (bus.CNT6),
      .al_hr_ones  (bus.AL_CNT10T),
      .al_hr_tens  (bus.AL_CNT3T),
      .al_min_ones (bus.AL_CNT10M),
      .al_min_tens (bus.AL_CNT6M),
      .trigger     (trigger)
   );

   // A key press swallows a coincident 1 Hz tick. An unusable SNOOZE (none
   // left in RING, or any SNOOZE while snoozing) counts as no key.
   logic          snz_ok;
   logic          ring_tick;
   logic          snz_tick;
   logic          timer_last;
   logic [TW-1:0] timer_dec;

   assign snz_ok     = bus.SNOOZE && (snz_left != 2'd0);
   assign ring_tick  = bus.ENABLE && !bus.STOP && !snz_ok;
   assign snz_tick   = bus.ENABLE && !bus.STOP;
   assign timer_last = (timer == TW'(1));
   assign timer_dec  = (timer != '0) ? timer - TW'(1) : timer;

   // Ring/snooze FSM with registered BUZZ/LED; tone phase restarts at 0 on
   // every entry to RING so each ring starts with a silent half-period.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= ST_IDLE;
         timer    <= '0;
         snz_left <= SNZ_MAX;
         phase    <= 1'b0;
         cadence  <= 1'b0;
         buzz     <= 1'b0;
         led      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  state    <= ST_RING;
                  timer    <= TW'(RING_SEC);
                  snz_left <= SNZ_MAX;
                  phase    <= 1'b0;
                  cadence  <= 1'b1;
                  buzz     <= 1'b0;
                  led      <= 1'b1;
               end
            end
            ST_RING: begin
               if (!bus.ARM || bus.STOP || (ring_tick && timer_last)) begin
                  state <= ST_IDLE;
                  timer <= '0;
                  buzz  <= 1'b0;
                  led   <= 1'b0;
               end else if (snz_ok) begin
                  state    <= ST_SNOOZE;
                  timer    <= TW'(SNOOZE_SEC);
                  snz_left <= snz_left - 2'd1;
                  buzz     <= 1'b0;
                  led      <= 1'b0;
               end else begin
                  if (ring_tick) timer <= timer_dec;
                  phase   <= phase ^ bus.ENABLE_BUZZ;
                  cadence <= cadence ^ ring_tick;
                  buzz    <= (phase ^ bus.ENABLE_BUZZ) & (cadence ^ ring_tick);
               end
            end
            ST_SNOOZE: begin
               if (!bus.ARM || bus.STOP) begin
                  state <= ST_IDLE;
                  timer <= '0;
                  led   <= 1'b0;
               end else if (snz_tick && timer_last) begin
                  state   <= ST_RING;
                  timer   <= TW'(RING_SEC);
                  phase   <= 1'b0;
                  cadence <= 1'b1;
                  buzz    <= 1'b0;
                  led     <= 1'b1;
               end else if (snz_tick) begin
                  timer <= timer_dec;
                  led   <= ~led;
               end
            end
            default: begin
               state <= ST_IDLE;
               buzz  <= 1'b0;
               led   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.STATE    = state;
   assign bus.SNZ_LEFT = snz_left;
   assign bus.BUZZ     = buzz;
   assign bus.LED      = led;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Directed bench for alarm_snooze_ctrl with an event-count reference model.
module tb_alarm_snooze_ctrl;

   localparam int RING_S = 4;
   localparam int SNZ_S  = 3;
   localparam int MAX_S  = 2;
   localparam int AL_HH  = 7;
   localparam int AL_MM  = 30;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   int   hh = 7, mm = 29, ss = 59;

   alarm_snooze_ctrl_if bus();

   alarm_snooze_ctrl #(
      .RING_SEC   (RING_S),
      .SNOOZE_SEC (SNZ_S),
      .MAX_SNOOZE (MAX_S)
   ) dut (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: mode plus counts of ticks/tones since entering the mode.
   // Time left is duration - elapsed; BUZZ on while the elapsed second count
   // is even and an odd number of tone ticks have passed.
   int m_mode    = 0;
   int m_elapsed = 0;
   int m_tones   = 0;
   int m_snz     = MAX_S;
   bit m_prev    = 1'b1;

   always @(posedge clk or negedge rst_n) begin
      bit mt, trig;
      if (!rst_n) begin
         m_mode = 0; m_elapsed = 0; m_tones = 0; m_snz = MAX_S; m_prev = 1'b1;
      end else begin
         mt     = (hh == AL_HH) && (mm == AL_MM) && (ss == 0);
         trig   = mt && !m_prev && bus.ARM;
         m_prev = mt;
         case (m_mode)
            0: if (trig) begin
               m_mode = 1; m_elapsed = 0; m_tones = 0; m_snz = MAX_S;
            end
            1: begin
               if (!bus.ARM || bus.STOP) m_mode = 0;
               else if (bus.SNOOZE && m_snz > 0) begin
                  m_mode = 2; m_elapsed = 0; m_snz = m_snz - 1;
               end else begin
                  if (bus.ENABLE) m_elapsed = m_elapsed + 1;
                  if (m_elapsed == RING_S) m_mode = 0;
                  else if (bus.ENABLE_BUZZ) m_tones = m_tones + 1;
               end
            end
            default: begin
               if (!bus.ARM || bus.STOP) m_mode = 0;
               else if (bus.ENABLE) begin
                  m_elapsed = m_elapsed + 1;
                  if (m_elapsed == SNZ_S) begin
                     m_mode = 1; m_elapsed = 0; m_tones = 0;
                  end
               end
            end
         endcase
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the clock edge.
   always @(negedge clk) begin
      int e_led, e_buzz;
      e_led  = (m_mode == 1) ? 1 : (m_mode == 2) ? (m_elapsed % 2) : 0;
      e_buzz = (m_mode == 1 && (m_elapsed % 2) == 0 && (m_tones % 2) == 1) ? 1 : 0;
      check("model_state", int'(bus.STATE), m_mode);
      check("model_snz",   int'(bus.SNZ_LEFT), m_snz);
      check("model_led",   int'(bus.LED), e_led);
      check("model_buzz",  int'(bus.BUZZ), e_buzz);
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic set_time(input int h, input int m, input int s);
      hh = h; mm = m; ss = s;
      bus.CNT10T = 4'(h % 10);
      bus.CNT3T  = 2'(h / 10);
      bus.CNT10M = 4'(m % 10);
      bus.CNT6M  = 3'(m / 10);
      bus.CNT10  = 4'(s % 10);
      bus.CNT6   = 3'(s / 10);
   endtask

   task automatic pulse(input bit en, input bit eb, input bit snz, input bit stp);
      bus.ENABLE = en; bus.ENABLE_BUZZ = eb; bus.SNOOZE = snz; bus.STOP = stp;
      cyc();
      bus.ENABLE = 0; bus.ENABLE_BUZZ = 0; bus.SNOOZE = 0; bus.STOP = 0;
   endtask

   task automatic start_ring();
      set_time(7, 29, 59);
      cyc(2);
      set_time(7, 30, 0);
      cyc();
   endtask

   task automatic lit(input string name, input int st, input int snz, input int led, input int bz);
      check({name, "_state"}, int'(bus.STATE), st);
      check({name, "_snz"},   int'(bus.SNZ_LEFT), snz);
      check({name, "_led"},   int'(bus.LED), led);
      check({name, "_buzz"},  int'(bus.BUZZ), bz);
   endtask

   initial begin
      rst_n = 1'b1;
      bus.ENABLE = 0; bus.ENABLE_BUZZ = 0; bus.SNOOZE = 0; bus.STOP = 0; bus.ARM = 1;
      bus.AL_CNT10T = 4'd7; bus.AL_CNT3T = 2'd0; bus.AL_CNT10M = 4'd0; bus.AL_CNT6M = 3'd3;
      set_time(7, 29, 59);
      #1 rst_n = 1'b0;
      cyc(2);
      lit("reset", 0, 2, 0, 0);
      rst_n = 1'b1;
      cyc(2);

      // Trigger one cycle after the digits reach 07:30:00; tone during on-second.
      set_time(7, 30, 0);
      cyc();
      lit("trigger", 1, 2, 1, 0);
      pulse(0, 1, 0, 0); lit("tone1", 1, 2, 1, 1);
      pulse(0, 1, 0, 0); lit("tone2", 1, 2, 1, 0);
      pulse(0, 1, 0, 0); lit("tone3", 1, 2, 1, 1);
      pulse(1, 0, 0, 0); lit("off_second", 1, 2, 1, 0);
      pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
      check("ring_3ticks_state", int'(bus.STATE), 1);
      pulse(1, 0, 0, 0); lit("auto_stop", 0, 2, 0, 0);
      for (int s = 1; s < 60; s += 7) begin
         set_time(7, 30, s);
         cyc(2);
      end
      set_time(7, 31, 0);
      cyc(2);
      check("no_retrigger", int'(bus.STATE), 0);

      // Snooze cycle, snooze exhaustion, then STOP.
      start_ring();
      pulse(0, 0, 1, 0); lit("snooze1", 2, 1, 0, 0);
      pulse(1, 0, 0, 0); lit("blink1", 2, 1, 1, 0);
      pulse(1, 0, 0, 0); lit("blink2", 2, 1, 0, 0);
      pulse(1, 0, 0, 0); lit("rering", 1, 1, 1, 0);
      pulse(0, 0, 1, 0); lit("snooze2", 2, 0, 0, 0);
      pulse(0, 0, 1, 0); check("snz_key_in_snooze", int'(bus.STATE), 2);
      repeat (3) pulse(1, 0, 0, 0);
      check("rering2", int'(bus.STATE), 1);
      pulse(0, 0, 1, 0); lit("snooze_exhausted", 1, 0, 1, 0);
      pulse(0, 0, 0, 1); lit("stop", 0, 0, 0, 0);

      // STOP beats SNOOZE; key beats coincident tick.
      start_ring();
      pulse(0, 0, 1, 1); lit("stop_and_snooze", 0, 2, 0, 0);
      start_ring();
      pulse(1, 0, 1, 0); check("snz_with_tick", int'(bus.STATE), 2);
      pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
      check("tick_ignored", int'(bus.STATE), 2);
      pulse(1, 0, 0, 0); check("tick_ignored_rering", int'(bus.STATE), 1);
      pulse(0, 0, 0, 1);

      // ARM drop in SNOOZE; disarmed alarm time; arming inside the minute.
      start_ring();
      pulse(0, 0, 1, 0);
      bus.ARM = 0;
      cyc();
      lit("arm_drop", 0, 1, 0, 0);
      start_ring();
      cyc(2);
      check("disarmed_no_trigger", int'(bus.STATE), 0);
      bus.ARM = 1;
      cyc(3);
      check("arm_late_no_trigger", int'(bus.STATE), 0);

      // Reset mid-RING while matching; next day's 07:30 triggers again.
      start_ring();
      pulse(0, 0, 1, 0);
      repeat (3) pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
      lit("pre_reset_ring", 1, 1, 1, 1);
      rst_n = 1'b0;
      #1 lit("in_reset", 0, 2, 0, 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(4);
      lit("post_reset_match", 0, 2, 0, 0);
      start_ring();
      check("next_day_trigger", int'(bus.STATE), 1);
      pulse(0, 0, 0, 1);
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alarm_snooze_ctrl.md
Name: alarm_snooze_ctrl

Overview:
Downstream consumer of the time and alarm counters in the 24-hour clock top level. It compares the running HH:MM:SS digits against the alarm HH:MM and runs a ring/snooze state machine. It drives the buzzer pin (GPIO[34]) and the alarm LED (LEDR[0]), replacing the free-running key-driven buzzer with alarm-driven ringing.

Parameters:
RING_SEC, 60, number of 1 Hz ticks the alarm rings before auto-stop
SNOOZE_SEC, 300, number of 1 Hz ticks spent in snooze before re-ringing
MAX_SNOOZE, 3, snoozes allowed per alarm event (1..3)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
ENABLE  in  1  1 Hz tick, one CLK cycle wide
ENABLE_BUZZ  in  1  tone-rate tick, one CLK cycle wide
ARM  in  1  alarm on/off (onoff); 0 forces IDLE
SNOOZE  in  1  debounced key edge, one cycle wide
STOP  in  1  debounced key edge, one cycle wide
CNT10T, CNT3T  in  4, 2  current hour ones and tens (BCD)
CNT10M, CNT6M  in  4, 3  current minute ones and tens
CNT10, CNT6  in  4, 3  current second ones and tens
AL_CNT10T, AL_CNT3T  in  4, 2  alarm hour ones and tens
AL_CNT10M, AL_CNT6M  in  4, 3  alarm minute ones and tens
BUZZ  out  1  buzzer square wave
LED  out  1  alarm indicator
STATE  out  2  0 = IDLE, 1 = RING, 2 = SNOOZE
SNZ_LEFT  out  2  snoozes remaining

Behaviour:
- Reset (async, RESET = 0):
  - STATE = IDLE; BUZZ = 0; LED = 0; SNZ_LEFT = MAX_SNOOZE.
  - Tick timer = 0; tone phase = 0.
  - match_q = 1, so reset while the time matches the alarm cannot trigger.
- Match detection:
  - match is combinational: hours and minutes equal the alarm digits, and the seconds digits are both 0.
  - match_q registers match every CLK.
  - trigger = match & ~match_q & ARM (rising edge). Each alarm minute triggers at most once.
- IDLE:
  - On trigger: go to RING on the next cycle (1-cycle latency), load timer = RING_SEC, set SNZ_LEFT = MAX_SNOOZE.
- RING:
  - Timer decrements on each ENABLE.
  - Priority, highest first: ARM = 0 → IDLE; STOP → IDLE; SNOOZE with SNZ_LEFT > 0 → SNOOZE (timer = SNOOZE_SEC, SNZ_LEFT − 1); ENABLE with timer == 1 → IDLE.
  - SNOOZE with SNZ_LEFT == 0 is ignored; the state stays RING.
- SNOOZE state:
  - Timer decrements on each ENABLE.
  - Priority: ARM = 0 → IDLE; STOP → IDLE; ENABLE with timer == 1 → RING (timer = RING_SEC; SNZ_LEFT unchanged).
  - SNOOZE key is ignored.
- Triggers arriving in RING or SNOOZE are ignored; there is no restart.
- BUZZ:
  - In RING, the tone phase toggles on each ENABLE_BUZZ.
  - BUZZ = phase & cadence, where the cadence bit toggles on each ENABLE in RING (1 s on, 1 s off) and starts at 1 on entry to RING.
  - BUZZ = 0 in every other state, registered.
  - BUZZ falls to 0 in the same cycle STATE leaves RING.
- LED:
  - 1 constantly in RING.
  - In SNOOZE, toggles on each ENABLE, starting at 0 on entry.
  - 0 in IDLE.
- Simultaneous events:
  - ENABLE coinciding with STOP or SNOOZE: the key wins and the tick is ignored.
  - STOP and SNOOZE in the same cycle: STOP wins.
- Time edits:
  - Time-set edits that make match rise while in IDLE trigger like normal time.
- Widths:
  - Timer width = clog2(max(RING_SEC, SNOOZE_SEC) + 1).
  - The timer never wraps below 0; it is only decremented when ≥ 1.

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_RING, ST_SNOOZE) and the BCD digit widths used by the time counters.
- One sub-module, alarm_match: pure compare plus the match_q edge register, outputting trigger.
- The FSM, timer and outputs stay in the parent.

Test Plan:
- Bench runs with RING_SEC = 4, SNOOZE_SEC = 3, MAX_SNOOZE = 2.
- Alarm 07:30, ARM = 1, time steps 07:29:59 → 07:30:00 → STATE = 1 one cycle after the digits change; SNZ_LEFT = 2; LED = 1; BUZZ toggles on ENABLE_BUZZ during the on-second.
- Ring with no key input → after 4 ENABLE ticks STATE = 0, BUZZ = 0, LED = 0; the remainder of 07:30 causes no retrigger.
- SNOOZE pulse in RING → STATE = 2, SNZ_LEFT = 1, LED blinks; after 3 ENABLE ticks STATE = 1. Second SNOOZE → SNZ_LEFT = 0. Third SNOOZE → STATE stays 1.
- STOP and SNOOZE in the same cycle during RING → STATE = 0; SNZ_LEFT unchanged.
- ARM dropped during SNOOZE → STATE = 0 next cycle; ARM = 0 at 07:30:00 → no trigger.
- Reset asserted mid-RING at 07:30:00, released while the time still matches → STATE = 0, BUZZ = 0, SNZ_LEFT = 2, no trigger until the next day's 07:30:00.
